// File: rtl/ibus_pkg.sv
// Shared constants for the instruction class tracker.
// Class bit indices, opcode/funct codes, Tnew/Tuse values.
package ibus_pkg;

    localparam int IBW = 20;

    localparam int C_ADDU = 0;
    localparam int C_SUBU = 1;
    localparam int C_SLT  = 2;
    localparam int C_SLL  = 3;
    localparam int C_JR   = 4;
    localparam int C_JALR = 5;
    localparam int C_ADDI = 6;
    localparam int C_ORI  = 7;
    localparam int C_LUI  = 8;
    localparam int C_LW   = 9;
    localparam int C_LB   = 10;
    localparam int C_LH   = 11;
    localparam int C_SW   = 12;
    localparam int C_SB   = 13;
    localparam int C_SH   = 14;
    localparam int C_BEQ  = 15;
    localparam int C_BNE  = 16;
    localparam int C_JAL  = 17;
    localparam int C_J    = 18;
    localparam int C_ILL  = 19;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_SLT  = 6'h2a;

    localparam int TNEW_LOAD = 2;
    localparam int TNEW_ALU  = 1;
    localparam int TNEW_LINK = 0;
    localparam int TNEW_NONE = 0;

    localparam int TUSE_BR    = 0;
    localparam int TUSE_ALU   = 1;
    localparam int TUSE_LD    = 1;
    localparam int TUSE_ST_RS = 1;
    localparam int TUSE_ST_RT = 2;

    localparam logic [4:0] REG_RA = 5'd31;

endpackage

// File: rtl/ibus_decode.sv
// Combinational class decoder: instr -> one-hot ibus, dest, tnew,
// rs/rt with their use flags and Tuse values.
module ibus_decode
    import ibus_pkg::*;
#(
    parameter int TNEW_W = 2
) (
    input  logic [31:0]       instr,
    output logic [IBW-1:0]    ibus,
    output logic [4:0]        dest,
    output logic [TNEW_W-1:0] tnew,
    output logic [4:0]        rs,
    output logic [4:0]        rt,
    output logic              uses_rs,
    output logic              uses_rt,
    output logic [TNEW_W-1:0] tuse_rs,
    output logic [TNEW_W-1:0] tuse_rt
);

    logic [5:0] op;
    logic [5:0] fn;
    logic [4:0] rd;
    logic       unused_shamt;
    logic       ld, st, alu_r, alu_i, br;

    assign op = instr[31:26];
    assign fn = instr[5:0];
    assign rs = instr[25:21];
    assign rt = instr[20:16];
    assign rd = instr[15:11];
    assign unused_shamt = ^instr[10:6];

    always_comb begin
        ibus = '0;
        unique case (op)
            OP_RTYPE: begin
                unique case (fn)
                    FN_ADDU: ibus[C_ADDU] = 1'b1;
                    FN_SUBU: ibus[C_SUBU] = 1'b1;
                    FN_SLT:  ibus[C_SLT]  = 1'b1;
                    FN_SLL:  ibus[C_SLL]  = 1'b1;
                    FN_JR:   ibus[C_JR]   = 1'b1;
                    FN_JALR: ibus[C_JALR] = 1'b1;
                    default: ibus[C_ILL]  = 1'b1;
                endcase
            end
            OP_ADDI: ibus[C_ADDI] = 1'b1;
            OP_ORI:  ibus[C_ORI]  = 1'b1;
            OP_LUI:  ibus[C_LUI]  = 1'b1;
            OP_LW:   ibus[C_LW]   = 1'b1;
            OP_LB:   ibus[C_LB]   = 1'b1;
            OP_LH:   ibus[C_LH]   = 1'b1;
            OP_SW:   ibus[C_SW]   = 1'b1;
            OP_SB:   ibus[C_SB]   = 1'b1;
            OP_SH:   ibus[C_SH]   = 1'b1;
            OP_BEQ:  ibus[C_BEQ]  = 1'b1;
            OP_BNE:  ibus[C_BNE]  = 1'b1;
            OP_JAL:  ibus[C_JAL]  = 1'b1;
            OP_J:    ibus[C_J]    = 1'b1;
            default: ibus[C_ILL]  = 1'b1;
        endcase
    end

    assign ld    = ibus[C_LW] | ibus[C_LB] | ibus[C_LH];
    assign st    = ibus[C_SW] | ibus[C_SB] | ibus[C_SH];
    assign alu_r = ibus[C_ADDU] | ibus[C_SUBU]
                 | ibus[C_SLT] | ibus[C_SLL];
    assign alu_i = ibus[C_ADDI] | ibus[C_ORI] | ibus[C_LUI];
    assign br    = ibus[C_BEQ] | ibus[C_BNE];

    assign uses_rs = ibus[C_ADDU] | ibus[C_SUBU] | ibus[C_SLT]
                   | ibus[C_ADDI] | ibus[C_ORI] | ld | st | br
                   | ibus[C_JR] | ibus[C_JALR];
    assign uses_rt = ibus[C_ADDU] | ibus[C_SUBU] | ibus[C_SLT]
                   | ibus[C_SLL] | st | br;

    always_comb begin
        dest    = 5'd0;
        tnew    = TNEW_W'(TNEW_NONE);
        tuse_rs = TNEW_W'(TUSE_ALU);
        tuse_rt = TNEW_W'(TUSE_ALU);

        unique case (1'b1)
            alu_r | ibus[C_JALR]: dest = rd;
            alu_i | ld:           dest = rt;
            ibus[C_JAL]:          dest = REG_RA;
            default:              dest = 5'd0;
        endcase

        unique case (1'b1)
            ld:                        tnew = TNEW_W'(TNEW_LOAD);
            alu_r | alu_i:             tnew = TNEW_W'(TNEW_ALU);
            ibus[C_JAL] | ibus[C_JALR]: tnew = TNEW_W'(TNEW_LINK);
            default:                   tnew = TNEW_W'(TNEW_NONE);
        endcase

        unique case (1'b1)
            br | ibus[C_JR] | ibus[C_JALR]:
                tuse_rs = TNEW_W'(TUSE_BR);
            ld:      tuse_rs = TNEW_W'(TUSE_LD);
            st:      tuse_rs = TNEW_W'(TUSE_ST_RS);
            default: tuse_rs = TNEW_W'(TUSE_ALU);
        endcase

        unique case (1'b1)
            st:      tuse_rt = TNEW_W'(TUSE_ST_RT);
            br:      tuse_rt = TNEW_W'(TUSE_BR);
            default: tuse_rt = TNEW_W'(TUSE_ALU);
        endcase
    end

endmodule

// File: rtl/ibus_pipe_tracker.sv
// Tracks instruction class, dest and Tnew from D down the pipe and
// raises the D-stage hazard stall; stage k = slice k of stage_* buses.
module ibus_pipe_tracker #(
    parameter int NUM_STAGES = 4,
    parameter int IBW        = ibus_pkg::IBW,
    parameter int TNEW_W     = 2
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic [31:0]                  in_instr,
    input  logic                         ext_stall,
    input  logic                         flush,
    output logic                         stall_req,
    output logic                         stall_eff,
    output logic [IBW-1:0]               d_ibus,
    output logic [NUM_STAGES-1:0]        stage_valid,
    output logic [NUM_STAGES*IBW-1:0]    stage_ibus,
    output logic [NUM_STAGES*5-1:0]      stage_dest,
    output logic [NUM_STAGES*TNEW_W-1:0] stage_tnew
);

    logic [IBW-1:0]    dec_ibus;
    logic [4:0]        dec_dest, dec_rs, dec_rt;
    logic [TNEW_W-1:0] dec_tnew, dec_tur, dec_tut;
    logic              dec_urs, dec_urt;
    logic              in_real;

    ibus_decode #(.TNEW_W(TNEW_W)) u_dec (
        .instr   (in_instr),
        .ibus    (dec_ibus),
        .dest    (dec_dest),
        .tnew    (dec_tnew),
        .rs      (dec_rs),
        .rt      (dec_rt),
        .uses_rs (dec_urs),
        .uses_rt (dec_urt),
        .tuse_rs (dec_tur),
        .tuse_rt (dec_tut)
    );

    // An all-zero word is a bubble, not sll $0,$0,0.
    assign in_real = in_valid && (in_instr != 32'd0);

    logic [NUM_STAGES-1:0] v;
    logic [IBW-1:0]        ib [NUM_STAGES];
    logic [4:0]            ds [NUM_STAGES];
    logic [TNEW_W-1:0]     tn [NUM_STAGES];

    // Source operands of the instruction held in D.
    logic [4:0]        d_rs, d_rt;
    logic              d_urs, d_urt;
    logic [TNEW_W-1:0] d_tur, d_tut;

    assign stall_eff = stall_req | ext_stall;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                v[k]  <= 1'b0;
                ib[k] <= '0;
                ds[k] <= '0;
                tn[k] <= '0;
            end
            d_rs  <= '0;
            d_rt  <= '0;
            d_urs <= 1'b0;
            d_urt <= 1'b0;
            d_tur <= '0;
            d_tut <= '0;
        end else begin
            if (stall_eff) begin
                v[1]  <= 1'b0;
                ib[1] <= '0;
                ds[1] <= '0;
                tn[1] <= '0;
            end else begin
                v[1]  <= v[0];
                ib[1] <= ib[0];
                ds[1] <= ds[0];
                tn[1] <= tn[0];
                if (flush || !in_real) begin
                    v[0]  <= 1'b0;
                    ib[0] <= '0;
                    ds[0] <= '0;
                    tn[0] <= '0;
                    d_urs <= 1'b0;
                    d_urt <= 1'b0;
                end else begin
                    v[0]  <= 1'b1;
                    ib[0] <= dec_ibus;
                    ds[0] <= dec_dest;
                    tn[0] <= dec_tnew;
                    d_urs <= dec_urs;
                    d_urt <= dec_urt;
                end
                d_rs  <= dec_rs;
                d_rt  <= dec_rt;
                d_tur <= dec_tur;
                d_tut <= dec_tut;
            end
            // Past E the countdown saturates at zero.
            for (int k = 2; k < NUM_STAGES; k++) begin
                v[k]  <= v[k-1];
                ib[k] <= ib[k-1];
                ds[k] <= ds[k-1];
                tn[k] <= (tn[k-1] == '0) ? '0 : tn[k-1] - 1'b1;
            end
        end
    end

    logic [NUM_STAGES-1:1] m_rs, m_rt;

    for (genvar g = 1; g < NUM_STAGES; g++) begin : g_cmp
        assign m_rs[g] = v[g] && (ds[g] == d_rs);
        assign m_rt[g] = v[g] && (ds[g] == d_rt);
    end

    logic              hit_rs, hit_rt;
    logic [TNEW_W-1:0] tn_rs, tn_rt;

    // Walk oldest to youngest so the youngest match wins.
    always_comb begin
        hit_rs = 1'b0;
        hit_rt = 1'b0;
        tn_rs  = '0;
        tn_rt  = '0;
        for (int k = NUM_STAGES - 1; k >= 1; k--) begin
            if (m_rs[k]) begin
                hit_rs = 1'b1;
                tn_rs  = tn[k];
            end
            if (m_rt[k]) begin
                hit_rt = 1'b1;
                tn_rt  = tn[k];
            end
        end
    end

    assign stall_req = v[0] && (
        (d_urs && (d_rs != 5'd0) && hit_rs && (tn_rs > d_tur)) ||
        (d_urt && (d_rt != 5'd0) && hit_rt && (tn_rt > d_tut)));

    assign d_ibus      = ib[0];
    assign stage_valid = v;

    for (genvar g = 0; g < NUM_STAGES; g++) begin : g_out
        assign stage_ibus[g*IBW +: IBW]       = ib[g];
        assign stage_dest[g*5 +: 5]           = ds[g];
        assign stage_tnew[g*TNEW_W +: TNEW_W] = tn[g];
    end

endmodule
